sram_pixel_arbiter: RTL and testbench

SRAM_PIXEL_ARBITER -- requirements
Module: sram_pixel_arbiter

---
 rtl/sram_pixel_arbiter_pkg.sv | 14 +
 rtl/sram_rr_arb.sv | 17 +
 rtl/sram_pixel_arbiter.sv | 97 +++++++++
 tb/tb_sram_pixel_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sram_pixel_arbiter_pkg.sv
// sram_pixel_arbiter_pkg: shared region/state types, region base addresses and pixel layout
package sram_pixel_arbiter_pkg;
  typedef enum logic [1:0] {REG_TRG, REG_SRC, REG_ATLAS, REG_BAD} region_e;
  typedef enum logic [2:0] {IDLE, RD_HI, RD_LO, WR_HI, WR_LO} state_e;
  localparam int TRG_BASE_ADDR = 0;
  localparam int SRC_BASE_ADDR = 50;
  localparam int ATLAS_BASE_ADDR = 100;
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] gray;
  } pixel_t;
endpackage

// File: rtl/sram_rr_arb.sv
// sram_rr_arb: two-requester round-robin arbiter; the last-grant flag resets to write so read wins the first tie
module sram_rr_arb (
  input  logic clk,
  input  logic i_rst,
  input  logic en,
  input  logic req_rd,
  input  logic req_wr,
  output logic gnt_rd,
  output logic gnt_wr
);
  logic last_wr;
  assign gnt_rd = en && !i_rst && req_rd && (!req_wr || last_wr);
  assign gnt_wr = en && !i_rst && req_wr && (!req_rd || !last_wr);
  always_ff @(posedge clk)
    if (i_rst) last_wr <= 1'b1;
    else if (gnt_rd || gnt_wr) last_wr <= gnt_wr;
endmodule

// File: rtl/sram_pixel_arbiter.sv
// sram_pixel_arbiter: shares one 16-bit SRAM between a pixel reader and an ATLAS pixel writer, two words per pixel
module sram_pixel_arbiter
  import sram_pixel_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_PIXELS = 25,
  parameter int TRG_BASE   = TRG_BASE_ADDR,
  parameter int SRC_BASE   = SRC_BASE_ADDR,
  parameter int ATLAS_BASE = ATLAS_BASE_ADDR
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_rd_req,
  input  logic [1:0]            i_rd_region,
  input  logic [4:0]            i_rd_idx,
  output logic                  o_rd_gnt,
  output logic                  o_rd_valid,
  output logic [31:0]           o_rd_pixel,
  input  logic                  i_wr_req,
  input  logic [4:0]            i_wr_idx,
  input  logic [31:0]           i_wr_pixel,
  output logic                  o_wr_gnt,
  output logic                  o_wr_done,
  output logic                  o_err,
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  output logic                  o_sram_cs,
  output logic                  o_sram_we,
  output logic                  o_sram_oe,
  inout  wire  [DATA_WIDTH-1:0] io_sram_data
);
  state_e                state;
  logic [4:0]            idx_q;
  logic [ADDR_WIDTH-1:0] base_q, base_sel;
  pixel_t                wr_q;
  logic [DATA_WIDTH-1:0] rd_hi;
  logic                  rd_bad, wr_bad, act, rd_st, wr_st;
  sram_rr_arb u_arb (
    .clk    (clk),
    .i_rst  (i_rst),
    .en     (state == IDLE),
    .req_rd (i_rd_req),
    .req_wr (i_wr_req),
    .gnt_rd (o_rd_gnt),
    .gnt_wr (o_wr_gnt)
  );
  assign base_sel = i_rd_region == REG_SRC   ? ADDR_WIDTH'(SRC_BASE)
                  : i_rd_region == REG_ATLAS ? ADDR_WIDTH'(ATLAS_BASE)
                  :                            ADDR_WIDTH'(TRG_BASE);
  assign rd_bad = i_rd_region == REG_BAD || int'(i_rd_idx) >= NUM_PIXELS;
  assign wr_bad = int'(i_wr_idx) >= NUM_PIXELS;
  // bus decode is gated by reset so the SRAM goes idle in the same cycle reset rises
  assign act   = !i_rst && state != IDLE;
  assign rd_st = state == RD_HI || state == RD_LO;
  assign wr_st = state == WR_HI || state == WR_LO;
  assign o_sram_cs = act;
  assign o_sram_we = !(act && wr_st);
  assign o_sram_oe = !(act && rd_st);
  assign o_sram_addr = act ? base_q + ADDR_WIDTH'({idx_q, 1'b0}) + ADDR_WIDTH'(state == RD_LO || state == WR_LO) : '0;
  assign io_sram_data = !o_sram_we ? (state == WR_HI ? DATA_WIDTH'({wr_q.r, wr_q.g}) : DATA_WIDTH'({wr_q.b, wr_q.gray})) : 'z;
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state      <= IDLE;
      o_rd_valid <= 1'b0;
      o_wr_done  <= 1'b0;
      o_err      <= 1'b0;
      o_rd_pixel <= '0;
    end else begin
      o_rd_valid <= state == RD_LO;
      o_wr_done  <= state == WR_LO;
      o_err      <= (o_rd_gnt && rd_bad) || (o_wr_gnt && wr_bad);
      case (state)
        IDLE:
          if (o_rd_gnt) begin
            base_q <= base_sel;
            idx_q  <= i_rd_idx;
            state  <= rd_bad ? IDLE : RD_HI;
          end else if (o_wr_gnt) begin
            base_q <= ADDR_WIDTH'(ATLAS_BASE);
            idx_q  <= i_wr_idx;
            wr_q   <= i_wr_pixel;
            state  <= wr_bad ? IDLE : WR_HI;
          end
        RD_HI: begin
          rd_hi <= io_sram_data;
          state <= RD_LO;
        end
        RD_LO: begin
          o_rd_pixel <= 32'({rd_hi, io_sram_data});
          state      <= IDLE;
        end
        WR_HI:   state <= WR_LO;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_pixel_arbiter.sv
// tb_sram_pixel_arbiter: randomized transactions against a per-region pixel-array model and an SRAM array
module tb_sram_pixel_arbiter;
  logic        clk = 1'b0;
  logic        i_rst, rd_req, wr_req;
  logic [1:0]  rd_region;
  logic [4:0]  rd_idx, wr_idx;
  logic [31:0] wr_pixel;
  logic        o_rd_gnt, o_rd_valid, o_wr_gnt, o_wr_done, o_err;
  logic [31:0] o_rd_pixel;
  logic [9:0]  o_sram_addr;
  logic        o_sram_cs, o_sram_we, o_sram_oe;
  wire  [15:0] sram_dq;
  logic [15:0] mem [0:1023];
  logic [31:0] ref_pix [3][25];
  logic        loaded = 1'b0;
  int          vec = 0, miss = 0;

  always #5 clk = ~clk;

  sram_pixel_arbiter dut (
    .clk (clk), .i_rst (i_rst),
    .i_rd_req (rd_req), .i_rd_region (rd_region), .i_rd_idx (rd_idx),
    .o_rd_gnt (o_rd_gnt), .o_rd_valid (o_rd_valid), .o_rd_pixel (o_rd_pixel),
    .i_wr_req (wr_req), .i_wr_idx (wr_idx), .i_wr_pixel (wr_pixel),
    .o_wr_gnt (o_wr_gnt), .o_wr_done (o_wr_done), .o_err (o_err),
    .o_sram_addr (o_sram_addr), .o_sram_cs (o_sram_cs), .o_sram_we (o_sram_we),
    .o_sram_oe (o_sram_oe), .io_sram_data (sram_dq)
  );

  // asynchronous SRAM: combinational read, write committed mid-cycle
  assign sram_dq = (o_sram_cs && o_sram_we && !o_sram_oe) ? mem[o_sram_addr] : 16'hzzzz;

  function automatic int base_of(input int r);
    return r == 0 ? 0 : r == 1 ? 50 : 100;
  endfunction

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = 16'h0;
    wait (loaded);
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 25; i++) begin
        mem[base_of(r) + 2 * i]     = ref_pix[r][i][31:16];
        mem[base_of(r) + 2 * i + 1] = ref_pix[r][i][15:0];
      end
    forever begin
      @(negedge clk);
      if (o_sram_cs && !o_sram_we) mem[o_sram_addr] = sram_dq;
    end
  end

  task automatic xfer(input bit rd, input logic [1:0] region, input logic [4:0] idx, input logic [31:0] wpix,
                      output bit gnt, output int lat, output bit err, output logic [31:0] pix,
                      output int cs_n, output logic [9:0] a0, output logic [9:0] a1);
    lat = 0; err = 0; cs_n = 0; pix = '0; a0 = '0; a1 = '0;
    @(negedge clk);
    if (rd) begin rd_req = 1; rd_region = region; rd_idx = idx; end
    else begin wr_req = 1; wr_idx = idx; wr_pixel = wpix; end
    #1 gnt = rd ? o_rd_gnt : o_wr_gnt;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      rd_req = 0; wr_req = 0;
      #1;
      if (c == 1) begin err = o_err; a0 = o_sram_addr; end
      if (c == 2) a1 = o_sram_addr;
      cs_n += int'(o_sram_cs);
      if ((rd ? o_rd_valid : o_wr_done) && lat == 0) begin lat = c; pix = o_rd_pixel; end
    end
  endtask

  task automatic test_reset;
    i_rst = 1; rd_req = 1; wr_req = 1; rd_region = 0; rd_idx = 0; wr_idx = 0; wr_pixel = 0;
    repeat (3) @(negedge clk);
    #1;
    vec++; if ({o_rd_gnt, o_wr_gnt} !== 2'b00) begin miss++; $display("FAIL reset_gnt got %b exp 00", {o_rd_gnt, o_wr_gnt}); end
    vec++; if ({o_rd_valid, o_wr_done, o_err} !== 3'b000) begin miss++; $display("FAIL reset_pulses got %b exp 000", {o_rd_valid, o_wr_done, o_err}); end
    vec++; if (o_rd_pixel !== 32'h0) begin miss++; $display("FAIL reset_pixel got %h exp 0", o_rd_pixel); end
    vec++; if (o_sram_addr !== 10'h0) begin miss++; $display("FAIL reset_addr got %h exp 0", o_sram_addr); end
    vec++; if ({o_sram_cs, o_sram_we, o_sram_oe} !== 3'b011) begin miss++; $display("FAIL reset_ctl got %b exp 011", {o_sram_cs, o_sram_we, o_sram_oe}); end
    rd_req = 0; wr_req = 0;
    @(negedge clk);
    i_rst = 0;
  endtask

  task automatic test_read_directed;
    bit g, e; int lat, cs_n; logic [31:0] p; logic [9:0] a0, a1;
    xfer(1, 2'd0, 5'd0, 32'h0, g, lat, e, p, cs_n, a0, a1);
    vec++; if (g !== 1'b1) begin miss++; $display("FAIL trg_gnt got %b exp 1", g); end
    vec++; if (lat != 3) begin miss++; $display("FAIL trg_latency got %0d exp 3", lat); end
    vec++; if (p !== 32'hD0DB_EBC0) begin miss++; $display("FAIL trg_pixel got %h exp d0dbebc0", p); end
    vec++; if ({a0, a1} !== {10'd0, 10'd1}) begin miss++; $display("FAIL trg_addr got %0d,%0d exp 0,1", a0, a1); end
    xfer(1, 2'd1, 5'd0, 32'h0, g, lat, e, p, cs_n, a0, a1);
    vec++; if ({a0, a1} !== {10'd50, 10'd51}) begin miss++; $display("FAIL src_addr got %0d,%0d exp 50,51", a0, a1); end
    vec++; if (p !== 32'hD652_CC87) begin miss++; $display("FAIL src_pixel got %h exp d652cc87", p); end
    vec++; if (cs_n != 2 || e !== 1'b0) begin miss++; $display("FAIL src_cs_err got cs=%0d err=%b exp cs=2 err=0", cs_n, e); end
  endtask

  task automatic test_write_directed;
    bit g, e; int lat, cs_n; logic [31:0] p; logic [9:0] a0, a1;
    xfer(0, 2'd2, 5'd3, 32'h1234_5678, g, lat, e, p, cs_n, a0, a1);
    ref_pix[2][3] = 32'h1234_5678;
    vec++; if (g !== 1'b1 || lat != 3) begin miss++; $display("FAIL wr_gnt_done got gnt=%b lat=%0d exp gnt=1 lat=3", g, lat); end
    vec++; if ({a0, a1} !== {10'd106, 10'd107}) begin miss++; $display("FAIL wr_addr got %0d,%0d exp 106,107", a0, a1); end
    vec++; if ({mem[106], mem[107]} !== 32'h1234_5678) begin miss++; $display("FAIL wr_mem got %h%h exp 12345678", mem[106], mem[107]); end
    xfer(1, 2'd2, 5'd3, 32'h0, g, lat, e, p, cs_n, a0, a1);
    vec++; if (p !== 32'h1234_5678 || lat != 3) begin miss++; $display("FAIL wr_readback got %h lat=%0d exp 12345678 lat=3", p, lat); end
  endtask

  task automatic test_random;
    bit g, e, rd; int lat, cs_n; logic [31:0] p, v, last_pix; logic [9:0] a0, a1; logic [1:0] r; logic [4:0] i;
    last_pix = o_rd_pixel;
    for (int n = 0; n < 30; n++) begin
      rd = 1'($urandom_range(0, 1));
      r  = rd ? 2'($urandom_range(0, 2)) : 2'd2;
      i  = 5'($urandom_range(0, 24));
      v  = $urandom;
      xfer(rd, r, i, v, g, lat, e, p, cs_n, a0, a1);
      vec++; if (g !== 1'b1 || lat != 3 || e !== 1'b0) begin miss++; $display("FAIL rand_handshake n=%0d got gnt=%b lat=%0d err=%b exp 1,3,0", n, g, lat, e); end
      vec++; if (a0 !== 10'(base_of(int'(r)) + 2 * int'(i))) begin miss++; $display("FAIL rand_addr n=%0d got %0d exp %0d", n, a0, base_of(int'(r)) + 2 * int'(i)); end
      if (rd) begin
        vec++; if (p !== ref_pix[r][i]) begin miss++; $display("FAIL rand_read n=%0d r=%0d i=%0d got %h exp %h", n, r, i, p, ref_pix[r][i]); end
        last_pix = ref_pix[r][i];
      end else begin
        ref_pix[2][i] = v;
        vec++; if (o_rd_pixel !== last_pix) begin miss++; $display("FAIL rand_hold n=%0d got %h exp %h", n, o_rd_pixel, last_pix); end
      end
    end
  endtask

  task automatic test_errors;
    bit g, e; int lat, cs_n; logic [31:0] p; logic [9:0] a0, a1;
    xfer(1, 2'd0, 5'd25, 32'h0, g, lat, e, p, cs_n, a0, a1);
    vec++; if ({g, e} !== 2'b11 || cs_n != 0 || lat != 0) begin miss++; $display("FAIL err_idx25 got gnt=%b err=%b cs=%0d lat=%0d exp 1,1,0,0", g, e, cs_n, lat); end
    xfer(1, 2'd3, 5'd0, 32'h0, g, lat, e, p, cs_n, a0, a1);
    vec++; if ({g, e} !== 2'b11 || cs_n != 0 || lat != 0) begin miss++; $display("FAIL err_region3 got gnt=%b err=%b cs=%0d lat=%0d exp 1,1,0,0", g, e, cs_n, lat); end
    xfer(0, 2'd2, 5'd31, 32'hDEAD_BEEF, g, lat, e, p, cs_n, a0, a1);
    vec++; if ({g, e} !== 2'b11 || cs_n != 0 || lat != 0) begin miss++; $display("FAIL err_wr31 got gnt=%b err=%b cs=%0d lat=%0d exp 1,1,0,0", g, e, cs_n, lat); end
    xfer(1, 2'd0, 5'd24, 32'h0, g, lat, e, p, cs_n, a0, a1);
    vec++; if (e !== 1'b0 || lat != 3 || p !== ref_pix[0][24]) begin miss++; $display("FAIL edge_idx24 got err=%b lat=%0d pix=%h exp 0,3,%h", e, lat, p, ref_pix[0][24]); end
  endtask

  task automatic test_back_to_back;
    logic [1:0] eg, ec; logic [31:0] v, old;
    i_rst = 1;
    repeat (2) @(negedge clk);
    i_rst = 0;
    v = $urandom; old = ref_pix[2][7];
    @(negedge clk);
    rd_req = 1; rd_region = 2'd2; rd_idx = 5'd7;
    wr_req = 1; wr_idx = 5'd7; wr_pixel = v;
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      eg = (c % 3 == 0) ? (((c / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      ec = (c >= 3 && c % 3 == 0) ? ((((c - 3) / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      vec++; if ({o_wr_gnt, o_rd_gnt} !== eg) begin miss++; $display("FAIL b2b_gnt c=%0d got %b exp %b", c, {o_wr_gnt, o_rd_gnt}, eg); end
      vec++; if ({o_wr_done, o_rd_valid} !== ec) begin miss++; $display("FAIL b2b_done c=%0d got %b exp %b", c, {o_wr_done, o_rd_valid}, ec); end
      if (ec == 2'b01) begin
        vec++; if (o_rd_pixel !== (c == 3 ? old : v)) begin miss++; $display("FAIL b2b_pixel c=%0d got %h exp %h", c, o_rd_pixel, c == 3 ? old : v); end
      end
    end
    ref_pix[2][7] = v;
    @(negedge clk);
    rd_req = 0; wr_req = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    bit g, e; int lat, cs_n; logic [31:0] p; logic [9:0] a0, a1;
    @(negedge clk);
    rd_req = 1; rd_region = 2'd1; rd_idx = 5'd4;
    #1;
    vec++; if (o_rd_gnt !== 1'b1) begin miss++; $display("FAIL mid_gnt got %b exp 1", o_rd_gnt); end
    @(negedge clk);
    rd_req = 0;
    @(negedge clk);
    i_rst = 1;
    #1;
    vec++; if (o_sram_cs !== 1'b0) begin miss++; $display("FAIL mid_cs_in_reset got %b exp 0", o_sram_cs); end
    @(negedge clk);
    #1;
    vec++; if ({o_rd_valid, o_sram_cs, o_sram_we, o_sram_oe} !== 4'b0011 || o_sram_addr !== 10'd0 || o_rd_pixel !== 32'h0) begin
      miss++; $display("FAIL mid_after got v/cs/we/oe=%b addr=%0d pix=%h exp 0011 0 0", {o_rd_valid, o_sram_cs, o_sram_we, o_sram_oe}, o_sram_addr, o_rd_pixel);
    end
    i_rst = 0;
    xfer(1, 2'd1, 5'd4, 32'h0, g, lat, e, p, cs_n, a0, a1);
    vec++; if (p !== ref_pix[1][4] || lat != 3) begin miss++; $display("FAIL mid_recover got %h lat=%0d exp %h lat=3", p, lat, ref_pix[1][4]); end
  endtask

  initial begin
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 25; i++) ref_pix[r][i] = $urandom;
    ref_pix[0][0] = 32'hD0DB_EBC0;
    ref_pix[1][0] = 32'hD652_CC87;
    loaded = 1'b1;
    test_reset;
    test_read_directed;
    test_write_directed;
    test_errors;
    test_random;
    test_back_to_back;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
